// File: rtl/wb_pkg.sv
// wb_pkg: shared write-back widths and request record for the register-file write port
package wb_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO buffering load returns until the write port is free
module wb_fifo
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  wb_req_t mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign empty = cnt_q == '0;
  assign head = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  // pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= din;
      wr_q <= do_push ? wr_q + 1'b1 : wr_q;
      rd_q <= do_pop ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/reg_wb_sched.sv
// reg_wb_sched: shares the register-file write port between ALU results and buffered load returns
module reg_wb_sched #(
  parameter int DATA_WIDTH = wb_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = wb_pkg::ADDR_WIDTH,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_waddr,
  input  logic [DATA_WIDTH-1:0] alu_wdata,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  ld_issue,
  input  logic [ADDR_WIDTH-1:0] ld_issue_addr,
  input  logic [ADDR_WIDTH-1:0] chk_raddr1,
  input  logic [ADDR_WIDTH-1:0] chk_raddr2,
  output logic                  hazard,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);
  import wb_pkg::*;
  wb_req_t din, head;
  logic full, empty, fifo_ne, mem_wins, mem_gnt, alu_gnt, contend;
  logic prio_q, prio_d;
  logic [2**ADDR_WIDTH-1:0] pend_q, pend_d;
  assign din = '{waddr: mem_waddr, wdata: mem_wdata};
  wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(mem_valid && mem_ready), .pop(mem_gnt),
    .din(din), .head(head), .full(full), .empty(empty)
  );
  assign fifo_ne = !empty;
  assign mem_wins = fifo_ne && (full || prio_q);
  assign alu_ready = !rst && !mem_wins;
  assign mem_ready = !full;
  assign mem_gnt = !rst && fifo_ne && (mem_wins || !alu_valid);
  assign alu_gnt = alu_valid && alu_ready;
  assign contend = !rst && fifo_ne && alu_valid;
  assign rf_waddr = mem_gnt ? head.waddr : alu_waddr;
  assign rf_wdata = mem_gnt ? head.wdata : alu_wdata;
  assign rf_wen = (mem_gnt || alu_gnt) && rf_waddr != '0;
  assign hazard = (chk_raddr1 != '0 && pend_q[chk_raddr1]) || (chk_raddr2 != '0 && pend_q[chk_raddr2]);
  assign prio_d = contend ? !prio_q : prio_q;
  // scoreboard next state: drained load clears its bit, a new issue sets (set wins)
  always_comb begin
    pend_d = pend_q;
    if (mem_gnt) pend_d[head.waddr] = 1'b0;
    if (ld_issue && ld_issue_addr != '0) pend_d[ld_issue_addr] = 1'b1;
  end
  // scoreboard and round-robin priority registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      prio_q <= 1'b1;
    end else begin
      pend_q <= pend_d;
      prio_q <= prio_d;
    end
  end
endmodule

// File: doc/reg_wb_sched.md
# reg_wb_sched

Write-back scheduler for the MIPS core register file. It shares the single register-file write port between two requesters: the ALU result path and the SoC memory load-return path, which may arrive late. Load returns are buffered in a small FIFO. A pending-load scoreboard tells the decode stage when a source register still awaits its load data. It sits between the execute/memory stages and `reg_file`, and drives `wen`/`waddr`/`wdata` directly.

## Interface
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 5, register address width (2^ADDR_WIDTH registers)
- FIFO_DEPTH, 2, load-return buffer entries (power of two, ≥2)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU write-back request
- alu_ready  out  1  ALU request granted this cycle
- alu_waddr  in  ADDR_WIDTH  ALU destination register
- alu_wdata  in  DATA_WIDTH  ALU result
- mem_valid  in  1  load-return data valid
- mem_ready  out  1  FIFO can accept (= !full)
- mem_waddr  in  ADDR_WIDTH  load destination register
- mem_wdata  in  DATA_WIDTH  load data
- ld_issue  in  1  load issued this cycle; mark destination pending
- ld_issue_addr  in  ADDR_WIDTH  destination of issued load
- chk_raddr1, chk_raddr2  in  ADDR_WIDTH  decode-stage source registers
- hazard  out  1  a checked source is pending
- rf_wen  out  1  to reg_file wen
- rf_waddr  out  ADDR_WIDTH  to reg_file waddr
- rf_wdata  out  DATA_WIDTH  to reg_file wdata

## Operation
- Memory transfer: mem_valid && mem_ready enqueues {mem_waddr, mem_wdata} at the clock edge.
- Arbitration, evaluated combinationally each cycle between the FIFO head (fifo_nonempty) and alu_valid:
  - Only one requester present: that requester is granted.
  - Both present: the FIFO wins if it is full or `prio_mem`=1; otherwise the ALU wins.
  - `prio_mem` toggles after every contended grant. It resets to 1.
- alu_ready = !(fifo_nonempty && (fifo_full || prio_mem)). It does not depend on alu_valid.
- Granted source drives rf_waddr/rf_wdata. rf_wen = grant && (waddr != 0). A write to $0 is consumed, popped or acknowledged, but never asserted on rf_wen.
- No grant: rf_wen=0, rf_waddr/rf_wdata = ALU inputs (don't-care).
- Scoreboard: a `pending` bit vector with 2^ADDR_WIDTH bits.
  - Set bit ld_issue_addr on ld_issue when the address is nonzero.
  - Clear bit waddr when a FIFO entry is drained to the register file.
  - Set and clear of the same bit in the same cycle: set wins.
  - Bit 0 is never set.
- hazard = (chk_raddr1!=0 && pending[chk_raddr1]) || (chk_raddr2!=0 && pending[chk_raddr2]).
- Issuing a load to an already-pending register is illegal. The core must stall on hazard first. The bench flags it as a protocol error.
- ALU writes do not touch the scoreboard.

## Timing
- ALU path has zero latency. Grant and rf_* are valid in the same cycle, and the register file updates at the next edge.
- Memory path has at least one cycle of latency. Data accepted at edge N appears on rf_* in cycle N+1 at the earliest. There is no FIFO bypass.
- FIFO full: mem_ready=0 and the FIFO head is forced to win. Every full episode therefore drains at least one entry per cycle.
- Enqueue and dequeue in the same cycle while full are not allowed, because mem_ready is 0. When neither full nor empty, the occupancy is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Occupancy is held in a counter of log2(FIFO_DEPTH)+1 bits.
- hazard is combinational from the current `pending` value. A pending bit cleared at edge N drops hazard in cycle N+1.
- Reset values, applied at the first edge with rst=1:
  - FIFO empty, pending all zero, prio_mem=1.
  - Outputs: rf_wen=0, mem_ready=1, alu_ready=1, hazard=0.
- Reset mid-operation discards buffered loads and pending bits. While rst=1, rf_wen=0 and no grant is issued, so alu_ready=0.

## Structure
- Package `wb_pkg`: DATA_WIDTH/ADDR_WIDTH constants and a `wb_req_t` {waddr, wdata} struct, shared with reg_file and the core top.
- Sub-module `wb_fifo` (parameter FIFO_DEPTH): synchronous FIFO with push, pop, full, empty and head outputs.
- Arbiter and scoreboard live in reg_wb_sched.

## Test plan
- Reset, then ALU only: alu_valid=1, waddr=3, wdata=0x1234 → same-cycle rf_wen=1, rf_waddr=3. Next cycle reg_file[3]=0x1234. alu_ready stays 1.
- Load round trip: ld_issue addr=8 → hazard=1 for chk_raddr1=8. mem_valid addr=8, data=0xCAFE → rf_wen one cycle later. hazard=0 the cycle after the drain.
- Contention: FIFO holds one entry and alu_valid is held → grants go MEM, ALU, MEM… alternating. prio_mem flips on each contended cycle. No request is lost.
- Full FIFO: two loads accepted back-to-back with no drains → mem_ready=0. With alu_valid held, the FIFO wins regardless of prio_mem. mem_ready returns to 1 the cycle after a pop.
- $0 writes: ALU to addr 0 → alu_ready=1, rf_wen=0. ld_issue addr 0 → hazard stays 0 for chk_raddr1=0.
- Reset mid-operation: FIFO holds 2 entries and pending[5]=1. Assert rst one cycle → empty, hazard=0, no rf_wen for the stale entries afterwards.
